mul_wb: RTL and testbench
=========================

// Module: mul_wb
// PURPOSE
//  Writeback stage downstream of the multiply controller. Captures destination info at multiply
//  issue, waits for the multiply result, then writes RdLo and, for long forms, RdHi into the
//  register file through an arbitrated write port. Optionally updates the N and Z flags (S bit).
//  Drives o_busy so ID/EX stall register hazards until writeback completes.
// PARAMETERS
//  RA_W    4   register-file address width (r0..r15)
//  DW      32  data width of each result half
// PORTS
//  clk          in   1     clock, rising edge
//  rst          in   1     asynchronous reset, active-high
//  en           in   1     pipeline enable; 0 freezes all state and suppresses write strobes
//  i_issue      in   1     multiply issued to the controller this cycle (same cycle as its i_vld)
//  i_opcode     in   3     multiply opcode: MUL=000 MLA=001 UMULL=100 UMLAL=101 SMULL=110 SMLAL=111
//  i_rd_lo      in   RA_W  destination for low word (Rd for MUL/MLA)
//  i_rd_hi      in   RA_W  destination for high word (long forms only)
//  i_set_flags  in   1     S bit of the instruction
//  i_res_vld    in   1     controller result valid (high whenever the controller is not busy)
//  i_res_lo     in   DW    result bits [31:0]
//  i_res_hi     in   DW    result bits [63:32]
//  i_rf_gnt     in   1     write-port grant from register-file arbiter
//  o_rf_we      out  1     write request/strobe, port A
//  o_rf_waddr   out  RA_W  write address, port A
//  o_rf_wdata   out  DW    write data, port A
//  o_flag_we    out  1     one-cycle strobe: update N,Z (C,V untouched)
//  o_flag_n     out  1     N value
//  o_flag_z     out  1     Z value
//  o_busy       out  1     writeback pending; upstream must not issue and must stall readers
// BEHAVIOUR
//  - Reset: state IDLE; o_rf_we, o_flag_we, o_busy = 0; o_rf_waddr, o_rf_wdata, o_flag_n/z = 0.
//  - All transitions are qualified by en; en=0 holds state; o_rf_we = o_flag_we = 0.
//  - FSM: IDLE -> ARM on i_issue (latch opcode, rd_lo, rd_hi, set_flags).
//    ARM -> WAIT unconditionally (the controller asserts busy on the cycle after issue, so
//    i_res_vld in the ARM cycle is stale and is ignored).
//    WAIT -> WR_LO when i_res_vld=1 (latch i_res_lo/i_res_hi that cycle).
//    WR_LO: o_rf_we=1, addr=rd_lo, data=res_lo; on i_rf_gnt -> WR_HI if long (opcode[2]), else IDLE.
//    WR_HI: o_rf_we=1, addr=rd_hi, data=res_hi; on i_rf_gnt -> IDLE.
//    o_rf_we stays asserted with stable addr/data until granted.
//  - o_busy = (state != IDLE). i_issue while busy is a protocol violation: ignored, no state change.
//  - Flags: N = long ? res[63] : res[31]; Z = long ? (res[63:0]==0) : (res[31:0]==0).
//    o_flag_we pulses for exactly one cycle on the final granted write, only when set_flags=1.
//  - Latency: issue at cycle T, result valid at R (R >= T+2); earliest lo write is cycle R+1.
//  - rd_lo == rd_hi (architecturally unpredictable): lo written first, hi overwrites; hi wins.
//  - MLA/MUL ignore i_res_hi and never enter WR_HI.
//  - rst mid-operation: immediate return to IDLE; pending writes and flag update are dropped.
// CONFIGURATION
//  MUL_WB_DUAL_WR_EN defined: adds ports o_rf_we_b, o_rf_waddr_b[RA_W], o_rf_wdata_b[DW]; long
//   forms write lo on port A and hi on port B in the same WR_LO cycle (single i_rf_gnt covers both);
//   WR_HI is unreachable; on equal addresses the register file gives port B priority (hi wins).
//  Not defined: single port, sequential WR_LO/WR_HI as above.
// STRUCTURE
//  - mul_pkg (shared with the multiply controller): MUL_* opcode constants, state encoding
//    localparams (IDLE, ARM, WAIT, WR_LO, WR_HI), is_long helper (opcode[2]).
//  - Sub-module mul_flag_gen: combinational N/Z from the 64-bit result and the long flag.
// TESTING
//  1 MUL r3, i_res_vld at T+3, lo=0x00000005, gnt=1 -> one write r3=0x5 at T+4, o_busy low at T+5.
//  2 SMULLS lo r1/hi r2, res=0xFFFFFFFF_FFFFFFFE -> r1=0xFFFFFFFE, then r2=0xFFFFFFFF, flag_we once N=1 Z=0.
//  3 UMULLS res=0 with gnt withheld 3 cycles -> o_rf_we, r4/0 held stable 3 cycles; then Z=1 N=0.
//  4 MLAS res_lo=0x80000000, res_hi=0x12345678 -> only rd_lo written, N=1 Z=0, no WR_HI.
//  5 rst pulse while in WAIT -> o_busy=0 next cycle; later i_res_vld produces no write.
//  6 en=0 during WR_LO for 2 cycles -> no write strobe; resumes and writes once after en=1.

Source files
------------

// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - multiply opcodes, writeback state encoding and helpers
package mul_pkg;

  localparam logic [2:0] MUL_MUL   = 3'b000;
  localparam logic [2:0] MUL_MLA   = 3'b001;
  localparam logic [2:0] MUL_UMULL = 3'b100;
  localparam logic [2:0] MUL_UMLAL = 3'b101;
  localparam logic [2:0] MUL_SMULL = 3'b110;
  localparam logic [2:0] MUL_SMLAL = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARM   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_WR_LO = 3'd3,
    ST_WR_HI = 3'd4
  } wb_state_e;

  // Long forms (64-bit result, RdHi written) are identified by opcode bit 2.
  function automatic logic is_long(input logic [2:0] opcode);
    return opcode[2];
  endfunction

endpackage

// File: rtl/mul_wb_if.sv
// rtl/mul_wb_if.sv - issue, result, register-file write and flag signals of mul_wb
// MUL_WB_DUAL_WR_EN adds write port B.
interface mul_wb_if #(
  parameter int RA_W = 4,
  parameter int DW   = 32
);
  logic            i_issue;
  logic [2:0]      i_opcode;
  logic [RA_W-1:0] i_rd_lo;
  logic [RA_W-1:0] i_rd_hi;
  logic            i_set_flags;
  logic            i_res_vld;
  logic [DW-1:0]   i_res_lo;
  logic [DW-1:0]   i_res_hi;
  logic            i_rf_gnt;
  logic            o_rf_we;
  logic [RA_W-1:0] o_rf_waddr;
  logic [DW-1:0]   o_rf_wdata;
  logic            o_flag_we;
  logic            o_flag_n;
  logic            o_flag_z;
  logic            o_busy;
`ifdef MUL_WB_DUAL_WR_EN
  logic            o_rf_we_b;
  logic [RA_W-1:0] o_rf_waddr_b;
  logic [DW-1:0]   o_rf_wdata_b;
`endif

  modport slave (
    input  i_issue, i_opcode, i_rd_lo, i_rd_hi, i_set_flags,
    input  i_res_vld, i_res_lo, i_res_hi, i_rf_gnt,
`ifdef MUL_WB_DUAL_WR_EN
    output o_rf_we_b, o_rf_waddr_b, o_rf_wdata_b,
`endif
    output o_rf_we, o_rf_waddr, o_rf_wdata,
    output o_flag_we, o_flag_n, o_flag_z, o_busy
  );

  modport master (
    output i_issue, i_opcode, i_rd_lo, i_rd_hi, i_set_flags,
    output i_res_vld, i_res_lo, i_res_hi, i_rf_gnt,
`ifdef MUL_WB_DUAL_WR_EN
    input  o_rf_we_b, o_rf_waddr_b, o_rf_wdata_b,
`endif
    input  o_rf_we, o_rf_waddr, o_rf_wdata,
    input  o_flag_we, o_flag_n, o_flag_z, o_busy
  );

endinterface

// File: rtl/mul_flag_gen.sv
// rtl/mul_flag_gen.sv - N/Z flags of a 32-bit or 64-bit multiply result
module mul_flag_gen #(
  parameter int DW = 32
) (
  input  logic [DW-1:0] res_lo,
  input  logic [DW-1:0] res_hi,
  input  logic          long_op,
  output logic          flag_n,
  output logic          flag_z
);

  assign flag_n = long_op ? res_hi[DW-1] : res_lo[DW-1];
  assign flag_z = (res_lo == '0) && (!long_op || (res_hi == '0));

endmodule

// File: rtl/mul_wb.sv
// rtl/mul_wb.sv - multiply writeback: latch destination at issue, write RdLo/RdHi, update N/Z
// MUL_WB_DUAL_WR_EN: long forms write RdHi on port B in the same cycle as RdLo.
module mul_wb
  import mul_pkg::*;
#(
  parameter int RA_W = 4,
  parameter int DW   = 32
) (
  input logic   clk,
  input logic   rst,
  input logic   en,
  mul_wb_if.slave bus
);

  wb_state_e       state_q, state_d;
  logic            long_q;
  logic            set_flags_q;
  logic [RA_W-1:0] rd_lo_q, rd_hi_q;
  logic [DW-1:0]   res_lo_q, res_hi_q;
  logic            gen_n, gen_z;

  logic            rf_we;
  logic [RA_W-1:0] rf_waddr;
  logic [DW-1:0]   rf_wdata;
  logic            flag_we, flag_n, flag_z;

  mul_flag_gen #(.DW(DW)) u_flag_gen (
    .res_lo  (res_lo_q),
    .res_hi  (res_hi_q),
    .long_op (long_q),
    .flag_n  (gen_n),
    .flag_z  (gen_z)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      long_q      <= 1'b0;
      set_flags_q <= 1'b0;
      rd_lo_q     <= '0;
      rd_hi_q     <= '0;
      res_lo_q    <= '0;
      res_hi_q    <= '0;
    end else if (en) begin
      state_q <= state_d;
      // Destination is only accepted from IDLE; an issue while busy is dropped.
      if (state_q == ST_IDLE && bus.i_issue) begin
        long_q      <= is_long(bus.i_opcode);
        set_flags_q <= bus.i_set_flags;
        rd_lo_q     <= bus.i_rd_lo;
        rd_hi_q     <= bus.i_rd_hi;
      end
      if (state_q == ST_WAIT && bus.i_res_vld) begin
        res_lo_q <= bus.i_res_lo;
        res_hi_q <= bus.i_res_hi;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    rf_we    = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    flag_we  = 1'b0;
    flag_n   = 1'b0;
    flag_z   = 1'b0;
`ifdef MUL_WB_DUAL_WR_EN
    bus.o_rf_we_b    = 1'b0;
    bus.o_rf_waddr_b = '0;
    bus.o_rf_wdata_b = '0;
`endif
    case (state_q)
      ST_IDLE:  if (bus.i_issue) state_d = ST_ARM;
      // Result valid seen in ARM is stale: the controller has not gone busy yet.
      ST_ARM:   state_d = ST_WAIT;
      ST_WAIT:  if (bus.i_res_vld) state_d = ST_WR_LO;
      ST_WR_LO: begin
        rf_we    = en;
        rf_waddr = rd_lo_q;
        rf_wdata = res_lo_q;
        flag_n   = gen_n;
        flag_z   = gen_z;
`ifdef MUL_WB_DUAL_WR_EN
        bus.o_rf_we_b    = en && long_q;
        bus.o_rf_waddr_b = long_q ? rd_hi_q : '0;
        bus.o_rf_wdata_b = long_q ? res_hi_q : '0;
        if (bus.i_rf_gnt) begin
          state_d = ST_IDLE;
          flag_we = en && set_flags_q;
        end
`else
        if (bus.i_rf_gnt) begin
          state_d = long_q ? ST_WR_HI : ST_IDLE;
          flag_we = en && set_flags_q && !long_q;
        end
`endif
      end
      ST_WR_HI: begin
        rf_we    = en;
        rf_waddr = rd_hi_q;
        rf_wdata = res_hi_q;
        flag_n   = gen_n;
        flag_z   = gen_z;
        if (bus.i_rf_gnt) begin
          state_d = ST_IDLE;
          flag_we = en && set_flags_q;
        end
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  assign bus.o_rf_we    = rf_we;
  assign bus.o_rf_waddr = rf_waddr;
  assign bus.o_rf_wdata = rf_wdata;
  assign bus.o_flag_we  = flag_we;
  assign bus.o_flag_n   = flag_n;
  assign bus.o_flag_z   = flag_z;
  assign bus.o_busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mul_wb.sv
// tb/tb_mul_wb.sv - scoreboard bench for mul_wb with directed multiply writebacks
module tb_mul_wb;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b1;
  int   n_chk  = 0;
  int   n_pass = 0;

  typedef struct {
    logic [3:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t        wr_q[$];
  logic [1:0] fl_q[$];

  mul_wb_if #(.RA_W(4), .DW(32)) bus ();

  mul_wb #(.RA_W(4), .DW(32)) dut (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] opc, input logic [3:0] lo, input logic [3:0] hi,
                       input logic sf);
    bus.i_issue     = 1'b1;
    bus.i_opcode    = opc;
    bus.i_rd_lo     = lo;
    bus.i_rd_hi     = hi;
    bus.i_set_flags = sf;
    cyc();
    bus.i_issue = 1'b0;
  endtask

  task automatic result(input logic [31:0] lo, input logic [31:0] hi);
    bus.i_res_vld = 1'b1;
    bus.i_res_lo  = lo;
    bus.i_res_hi  = hi;
    cyc();
    bus.i_res_vld = 1'b0;
  endtask

  // Monitor: every granted write strobe and every flag strobe must match the next expectation.
  always @(negedge clk) begin
    if (!rst && bus.o_rf_we && bus.i_rf_gnt) begin
      if (wr_q.size() == 0) begin
        n_chk++;
        $display("FAIL wr_unexpected: got r%0d=%h expected no write", bus.o_rf_waddr, bus.o_rf_wdata);
      end else begin
        wr_t e;
        e = wr_q.pop_front();
        chk("wr_addr", 64'(bus.o_rf_waddr), 64'(e.addr));
        chk("wr_data", 64'(bus.o_rf_wdata), 64'(e.data));
      end
    end
    if (!rst && bus.o_flag_we) begin
      if (fl_q.size() == 0) begin
        n_chk++;
        $display("FAIL flag_unexpected: got nz=%b%b expected no flag strobe", bus.o_flag_n, bus.o_flag_z);
      end else begin
        logic [1:0] f;
        f = fl_q.pop_front();
        chk("flag_nz", 64'({bus.o_flag_n, bus.o_flag_z}), 64'(f));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_issue = 0; bus.i_opcode = 0; bus.i_rd_lo = 0; bus.i_rd_hi = 0;
    bus.i_set_flags = 0; bus.i_res_vld = 0; bus.i_res_lo = 0; bus.i_res_hi = 0;
    bus.i_rf_gnt = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy",   64'(bus.o_busy), 0);
    chk("rst_we",     64'(bus.o_rf_we), 0);
    chk("rst_waddr",  64'(bus.o_rf_waddr), 0);
    chk("rst_wdata",  64'(bus.o_rf_wdata), 0);
    chk("rst_flag",   64'({bus.o_flag_we, bus.o_flag_n, bus.o_flag_z}), 0);
    cyc();
    rst = 1'b0;
    cyc();

    // 1: MUL r3, stale valid in ARM ignored, result at T+3, write at T+4, idle at T+5
    wr_q.push_back('{4'd3, 32'h5});
    issue(3'b000, 4'd3, 4'd15, 1'b0);
    bus.i_res_vld = 1'b1; bus.i_res_lo = 32'hDEADBEEF;
    cyc();
    bus.i_res_vld = 1'b0;
    cyc();
    result(32'h5, 32'h0);
    @(negedge clk);
    chk("t1_we",    64'(bus.o_rf_we), 1);
    chk("t1_busy",  64'(bus.o_busy), 1);
    cyc();
    @(negedge clk);
    chk("t1_idle",  64'(bus.o_busy), 0);
    chk("t1_we_off", 64'(bus.o_rf_we), 0);
    cyc();

    // 2: SMULLS r1/r2, lo then hi, one flag strobe on the hi write
    wr_q.push_back('{4'd1, 32'hFFFFFFFE});
    wr_q.push_back('{4'd2, 32'hFFFFFFFF});
    fl_q.push_back(2'b10);
    issue(3'b110, 4'd1, 4'd2, 1'b1);
    cyc();
    result(32'hFFFFFFFE, 32'hFFFFFFFF);
    @(negedge clk);
    chk("t2_lo_noflag", 64'(bus.o_flag_we), 0);
    cyc();
    @(negedge clk);
    chk("t2_hi_flag", 64'(bus.o_flag_we), 1);
    cyc();
    @(negedge clk);
    chk("t2_idle", 64'(bus.o_busy), 0);
    cyc();

    // 3: UMULLS r4/r5 result 0, grant withheld 3 cycles
    wr_q.push_back('{4'd4, 32'h0});
    wr_q.push_back('{4'd5, 32'h0});
    fl_q.push_back(2'b01);
    issue(3'b100, 4'd4, 4'd5, 1'b1);
    cyc();
    bus.i_rf_gnt = 1'b0;
    result(32'h0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t3_hold_we",   64'(bus.o_rf_we), 1);
      chk("t3_hold_addr", 64'(bus.o_rf_waddr), 4);
      chk("t3_hold_data", 64'(bus.o_rf_wdata), 0);
      cyc();
    end
    bus.i_rf_gnt = 1'b1;
    cyc();
    cyc();
    @(negedge clk);
    chk("t3_idle", 64'(bus.o_busy), 0);
    cyc();

    // 4: MLAS r6, issue while busy ignored, hi result never written
    wr_q.push_back('{4'd6, 32'h80000000});
    fl_q.push_back(2'b10);
    issue(3'b001, 4'd6, 4'd7, 1'b1);
    cyc();
    issue(3'b000, 4'd11, 4'd12, 1'b0);
    result(32'h80000000, 32'h12345678);
    @(negedge clk);
    chk("t4_addr", 64'(bus.o_rf_waddr), 6);
    cyc();
    @(negedge clk);
    chk("t4_idle", 64'(bus.o_busy), 0);
    chk("t4_no_hi", 64'(bus.o_rf_we), 0);
    cyc();

    // 5: reset during WAIT drops the operation
    issue(3'b000, 4'd8, 4'd0, 1'b1);
    cyc();
    rst = 1'b1;
    @(negedge clk);
    chk("t5_busy", 64'(bus.o_busy), 0);
    cyc();
    rst = 1'b0;
    bus.i_res_vld = 1'b1; bus.i_res_lo = 32'h77;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t5_no_we", 64'(bus.o_rf_we), 0);
      cyc();
    end
    bus.i_res_vld = 1'b0;

    // 6: en low for 2 cycles in WR_LO suppresses the strobe, single write afterwards
    wr_q.push_back('{4'd9, 32'h00000AB0});
    issue(3'b000, 4'd9, 4'd0, 1'b0);
    cyc();
    result(32'h00000AB0, 32'h0);
    en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("t6_we_frozen", 64'(bus.o_rf_we), 0);
      chk("t6_busy",      64'(bus.o_busy), 1);
      cyc();
    end
    en = 1'b1;
    @(negedge clk);
    chk("t6_we", 64'(bus.o_rf_we), 1);
    cyc();
    @(negedge clk);
    chk("t6_idle", 64'(bus.o_busy), 0);
    cyc();

    // 7: UMULL with rd_lo == rd_hi, lo written first then hi
    wr_q.push_back('{4'd10, 32'h1});
    wr_q.push_back('{4'd10, 32'h2});
    issue(3'b100, 4'd10, 4'd10, 1'b0);
    cyc();
    result(32'h1, 32'h2);
    cyc();
    cyc();
    @(negedge clk);
    chk("t7_idle", 64'(bus.o_busy), 0);
    cyc();

    chk("wr_q_drained", 64'(wr_q.size()), 0);
    chk("fl_q_drained", 64'(fl_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
